// File: rtl/clk_div_pkg.sv
// Shared state encodings for the divided-clock blocks.
package clk_div_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERR    = 2'd3
  } state_t;
endpackage

// File: rtl/clk_div_sync.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_gate domain.
module clk_div_sync (
  input  logic clk_gate,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_gate or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock against EXP_DIV and tracks lock.
// Results land one cycle after the synced rise; a long stall counts as a mismatch.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int EXP_DIV  = 5,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk_gate,
  input  logic             resetn,
  input  logic             i_en,
  input  logic             i_div_clk,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_meas_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic [1:0]       o_state
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] EXP_P   = WIDTH'(EXP_DIV);
  localparam logic [WIDTH-1:0] TO_LIM  = WIDTH'(2 * EXP_DIV);
  localparam logic [WIDTH-1:0] HI_LO   = WIDTH'(EXP_DIV / 2);
  localparam logic [WIDTH-1:0] HI_HI   = WIDTH'((EXP_DIV + 1) / 2);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  logic             w_sync;
  logic             r_sync_d;
  logic             w_rise;
  logic [WIDTH-1:0] r_per;
  logic [WIDTH-1:0] r_hi;
  logic             r_armed;
  logic             r_to_fired;
  logic             w_meas;
  logic             w_match;
  logic             w_to;
  logic             w_mis;
  logic [3:0]       r_match;
  logic [3:0]       w_match_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_locked;
  logic             w_locked_nxt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high;
  logic             r_mv;

  clk_div_sync u_sync (
    .clk_gate (clk_gate),
    .resetn   (resetn),
    .i_d      (i_div_clk),
    .o_q      (w_sync)
  );

  assign w_rise  = w_sync & ~r_sync_d;
  assign w_meas  = i_en & w_rise & r_armed;
  assign w_match = (r_per == EXP_P) && ((r_hi == HI_LO) || (r_hi == HI_HI));
  // Only the first cycle past the limit reports; the flag re-arms on the next rise.
  assign w_to    = i_en & r_armed & ~w_rise & ~r_to_fired & (r_per > TO_LIM);
  assign w_mis   = (w_meas & ~w_match) | w_to;

  always_ff @(posedge clk_gate or negedge resetn) begin
    if (!resetn) begin
      r_sync_d   <= 1'b0;
      r_per      <= '0;
      r_hi       <= '0;
      r_armed    <= 1'b0;
      r_to_fired <= 1'b0;
      r_period   <= '0;
      r_high     <= '0;
      r_mv       <= 1'b0;
    end else begin
      r_sync_d <= w_sync;
      r_mv     <= w_meas;
      if (w_meas) begin
        r_period <= r_per;
        r_high   <= r_hi;
      end
      if (!i_en) begin
        r_per <= '0;
        r_hi  <= '0;
      end else if (w_rise) begin
        r_per <= WIDTH'(1);
        r_hi  <= WIDTH'(1);
      end else begin
        if (r_per != CNT_MAX) r_per <= r_per + WIDTH'(1);
        if (w_sync && (r_hi != CNT_MAX)) r_hi <= r_hi + WIDTH'(1);
      end
      if (!i_en || (r_state == ST_IDLE) || ((r_state == ST_ERR) && i_clr_err))
        r_armed <= 1'b0;
      else if (w_rise)
        r_armed <= 1'b1;
      if (w_rise || !r_armed)
        r_to_fired <= 1'b0;
      else if (w_to)
        r_to_fired <= 1'b1;
    end
  end

  always_ff @(posedge clk_gate or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_match  <= '0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_match  <= w_match_nxt;
      r_err    <= w_err_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_err_nxt   = r_err;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_match_nxt = '0;
      if (i_clr_err) w_err_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQ;
          if (i_clr_err) w_err_nxt = 1'b0;
        end
        ST_ACQ: begin
          if (i_clr_err) w_err_nxt = 1'b0;
          if (w_meas && w_match) begin
            w_match_nxt = r_match + 4'd1;
            if ((r_match + 4'd1) == LOCK_N) w_state_nxt = ST_LOCKED;
          end else if (w_mis) begin
            w_match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (i_clr_err) w_err_nxt = 1'b0;
          if (w_mis) begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
          end
        end
        ST_ERR: begin
          if (i_clr_err) begin
            w_state_nxt = ST_ACQ;
            w_err_nxt   = 1'b0;
            w_match_nxt = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_state      = r_state;
    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

  assign o_period     = r_period;
  assign o_high       = r_high;
  assign o_meas_valid = r_mv;
  assign o_locked     = r_locked;
  assign o_err        = r_err;
endmodule
